// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl
//   CBC chaining controller in front of an iterative AES-128 core. Accepts one
//   128-bit block at a time, XORs in the chaining value on the encrypt side
//   (or after the core on the decrypt side), drives the core through an
//   init/valid handshake and presents each result on a ready/valid stream.
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-high reset
//   start_in               pulse: latch key_in/iv_in/mode_in, open a chain
//   mode_in                1 = encrypt, 0 = decrypt
//   key_in, iv_in          AES-128 key and initial chaining value
//   s_valid_in/s_ready_out/s_data_in/s_last_in    input block stream
//   m_valid_out/m_ready_in/m_data_out/m_last_out  result stream
//   core_init_out/core_mode_out/core_key_out/core_data_out  to aes_core
//   core_data_in/core_valid_in                    from aes_core
//   busy_out               chain in progress (not IDLE, not ERROR)
//   error_out              core timed out; cleared by start_in or reset
//
// All 128-bit values use the core's row-major byte layout; every XOR here is
// a plain bitwise XOR, so no byte reordering ever happens in this block.
module aes_cbc_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic         mode_in,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic         s_valid_in,
  output logic         s_ready_out,
  input  logic [127:0] s_data_in,
  input  logic         s_last_in,
  output logic         m_valid_out,
  input  logic         m_ready_in,
  output logic [127:0] m_data_out,
  output logic         m_last_out,
  output logic         core_init_out,
  output logic         core_mode_out,
  output logic [127:0] core_key_out,
  output logic [127:0] core_data_out,
  input  logic [127:0] core_data_in,
  input  logic         core_valid_in,
  output logic         busy_out,
  output logic         error_out
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, OUTPUT, ERROR} state_t;

  state_t          state;
  logic [127:0]    chain_q;   // current chaining value
  logic [127:0]    blk_q;     // accepted block; becomes next chain on decrypt
  logic            last_q;
  logic [CW-1:0]   wait_cnt;

  // Every output is a register written only here, so outputs never glitch and
  // all of them drop to zero the moment rst_in rises.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      chain_q       <= '0;
      blk_q         <= '0;
      last_q        <= 1'b0;
      wait_cnt      <= '0;
      s_ready_out   <= 1'b0;
      m_valid_out   <= 1'b0;
      m_data_out    <= '0;
      m_last_out    <= 1'b0;
      core_init_out <= 1'b0;
      core_mode_out <= 1'b0;
      core_key_out  <= '0;
      core_data_out <= '0;
      busy_out      <= 1'b0;
      error_out     <= 1'b0;
    end else begin
      core_init_out <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (start_in) begin
            core_key_out  <= key_in;
            core_mode_out <= mode_in;
            chain_q       <= iv_in;
            error_out     <= 1'b0;
            busy_out      <= 1'b1;
            s_ready_out   <= 1'b1;
            state         <= ACCEPT;
          end
        end
        ACCEPT: begin
          // s_ready_out is always high here, so s_valid_in alone is the handshake
          if (s_valid_in) begin
            blk_q         <= s_data_in;
            last_q        <= s_last_in;
            core_data_out <= core_mode_out ? (s_data_in ^ chain_q) : s_data_in;
            s_ready_out   <= 1'b0;
            core_init_out <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // First WAIT cycle may still show the previous operation's valid,
          // so it is never sampled. A valid on the last allowed cycle beats
          // the timeout.
          if (wait_cnt != '0 && core_valid_in) begin
            m_data_out  <= core_mode_out ? core_data_in : (core_data_in ^ chain_q);
            chain_q     <= core_mode_out ? core_data_in : blk_q;
            m_last_out  <= last_q;
            m_valid_out <= 1'b1;
            state       <= OUTPUT;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            error_out <= 1'b1;
            busy_out  <= 1'b0;
            state     <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (m_ready_in) begin
            m_valid_out <= 1'b0;
            if (last_q) begin
              busy_out <= 1'b0;
              state    <= IDLE;
            end else begin
              s_ready_out <= 1'b1;
              state       <= ACCEPT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// tb_aes_cbc_ctrl
//   Bench for aes_cbc_ctrl. A behavioural AES-128 core (row-major byte layout,
//   programmable latency, stale valid held into the next operation, optional
//   "dead" mode) sits behind the controller. Expected CBC results come from
//   the chaining equations C_i = E(P_i ^ C_i-1), P_i = D(C_i) ^ C_i-1.
module tb_aes_cbc_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_in = 1'b0, mode_in = 1'b0;
  logic [127:0] key_in = '0, iv_in = '0;
  logic         s_valid_in = 1'b0, s_last_in = 1'b0;
  logic [127:0] s_data_in = '0;
  logic         s_ready_out;
  logic         m_valid_out, m_last_out;
  logic         m_ready_in = 1'b0;
  logic [127:0] m_data_out;
  logic         core_init_out, core_mode_out;
  logic [127:0] core_key_out, core_data_out;
  logic [127:0] core_data_in = '0;
  logic         core_valid_in = 1'b0;
  logic         busy_out, error_out;

  int n_vec = 0;
  int n_err = 0;
  int lat = 2;
  bit core_dead = 1'b0;

  always #5 clk = ~clk;

  aes_cbc_ctrl #(.MAX_WAIT(8)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start_in), .mode_in(mode_in),
    .key_in(key_in), .iv_in(iv_in),
    .s_valid_in(s_valid_in), .s_ready_out(s_ready_out), .s_data_in(s_data_in), .s_last_in(s_last_in),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .m_data_out(m_data_out), .m_last_out(m_last_out),
    .core_init_out(core_init_out), .core_mode_out(core_mode_out),
    .core_key_out(core_key_out), .core_data_out(core_data_out),
    .core_data_in(core_data_in), .core_valid_in(core_valid_in),
    .busy_out(busy_out), .error_out(error_out)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    for (int c = 0; c < 4; c++) w[c] = {gb(key, c), gb(key, 4+c), gb(key, 8+c), gb(key, 12+c)};
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    o = '0;
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          o[r*128 + 127 - 8*(row*4+c) -: 8] = w[4*r+c][31-8*row -: 8];
    return o;
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] v, input bit inv);
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = inv ? isb[gb(v, i)] : sb[gb(v, i)];
    return v;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] v, input bit inv);
    logic [127:0] n;
    n = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!inv) n[127-8*(r*4+c) -: 8] = gb(v, r*4 + (c+r)%4);
        else      n[127-8*(r*4+(c+r)%4) -: 8] = gb(v, r*4+c);
    return n;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] v, input bit inv);
    logic [7:0] cf [4];
    logic [7:0] a [4];
    logic [7:0] b;
    if (inv) begin cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9; end
    else     begin cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1; end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = gb(v, k*4+c);
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b ^= gmul(a[k], cf[(k - row + 4) % 4]);
        v[127-8*(row*4+c) -: 8] = b;
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] rk;
    logic [127:0]  s;
    rk = expand(key);
    s = pt ^ rk[127:0];
    for (int r = 1; r < 10; r++) s = mix_c(shift_r(sub_b(s, 0), 0), 0) ^ rk[r*128 +: 128];
    return shift_r(sub_b(s, 0), 0) ^ rk[1280 +: 128];
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [1407:0] rk;
    logic [127:0]  s;
    rk = expand(key);
    s = ct ^ rk[1280 +: 128];
    for (int r = 9; r >= 1; r--) s = mix_c(sub_b(shift_r(s, 1), 1) ^ rk[r*128 +: 128], 1);
    return sub_b(shift_r(s, 1), 1) ^ rk[127:0];
  endfunction

  // ---------------- core model ----------------
  // valid stays at its old value on the init edge (stale), drops next edge,
  // and rises with the result so it is visible in WAIT cycle index `lat`.
  int           age = 0;
  logic [127:0] pend = '0;
  always @(posedge clk) begin
    if (core_init_out) begin
      pend <= core_mode_out ? aes_enc(core_key_out, core_data_out) : aes_dec(core_key_out, core_data_out);
      age  <= 1;
    end else if (age != 0) begin
      if (!core_dead && age >= lat) begin
        core_valid_in <= 1'b1;
        core_data_in  <= pend;
        age           <= 0;
      end else begin
        core_valid_in <= 1'b0;
        age           <= age + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic all_outs();
    return |{s_ready_out, m_valid_out, m_data_out, m_last_out, core_init_out, core_mode_out,
             core_key_out, core_data_out, busy_out, error_out};
  endfunction

  task automatic do_start(input logic m, input logic [127:0] k, input logic [127:0] iv);
    start_in = 1'b1; mode_in = m; key_in = k; iv_in = iv;
    @(negedge clk);
    start_in = 1'b0; key_in = rnd128(); iv_in = rnd128(); mode_in = 1'($urandom);
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    bit done;
    done = 1'b0;
    s_valid_in = 1'b1; s_data_in = d; s_last_in = l;
    for (int i = 0; i < 100; i++) begin
      if (s_ready_out) begin
        @(negedge clk);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    s_valid_in = 1'b0; s_data_in = rnd128(); s_last_in = 1'($urandom);
    chk("s_handshake", 128'(done), 128'd1);
  endtask

  task automatic recv(input bit throttle, output logic [127:0] d, output logic l);
    bit got, pv, r;
    logic [127:0] pd;
    logic pl;
    got = 1'b0; pv = 1'b0; pd = '0; pl = 1'b0; d = '0; l = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pv) chk("m_hold_stable", {m_valid_out, m_last_out, m_data_out[125:0]}, {1'b1, pl, pd[125:0]});
      r = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid_out && r) begin
        d = m_data_out; l = m_last_out;
        m_ready_in = 1'b1;
        @(negedge clk);
        m_ready_in = 1'b0;
        got = 1'b1;
        break;
      end
      pv = m_valid_out; pd = m_data_out; pl = m_last_out;
      @(negedge clk);
    end
    chk("m_handshake", 128'(got), 128'd1);
  endtask

  typedef struct {
    string        nm;
    logic         mode;
    logic [127:0] key, iv, blk, exp;
    int           lat;
  } vec_t;

  vec_t         tbl [4];
  logic [127:0] pt [4];
  logic [127:0] ct [4];
  logic [127:0] k, iv, prev, d, p;
  logic         l;
  bit           seen;

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x]  = b;
      isb[b] = 8'(x);
    end

    tbl[0] = '{"kat_enc_iv0",  1'b1, 128'h2b28ab097eaef7cf15d2154f16a6883c, 128'h0,
               128'h6b2ee973c1403d93be9f7e17e296112a, 128'h3a0da824d77a9e667b36caefb460f397, 2};
    tbl[1] = '{"kat_enc_iv",   1'b1, 128'h2b28ab097eaef7cf15d2154f16a6883c, 128'h0004080c0105090d02060a0e03070b0f,
               128'h6b2ee973c1403d93be9f7e17e296112a, 128'h7681ce124919e9e9abb28e19ac469b7d, 7};
    tbl[2] = '{"kat_dec_iv",   1'b0, 128'h2b28ab097eaef7cf15d2154f16a6883c, 128'h0004080c0105090d02060a0e03070b0f,
               128'h7681ce124919e9e9abb28e19ac469b7d, 128'h6b2ee973c1403d93be9f7e17e296112a, 3};
    tbl[3] = '{"kat_dec_iv0",  1'b0, 128'h2b28ab097eaef7cf15d2154f16a6883c, 128'h0,
               128'h3a0da824d77a9e667b36caefb460f397, 128'h6b2ee973c1403d93be9f7e17e296112a, 5};

    // reset state
    @(negedge clk);
    chk("reset_outputs", 128'(all_outs()), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", 128'(all_outs()), 128'd0);

    // single-block known-answer vectors; lat 7 lands valid on the last WAIT cycle
    foreach (tbl[i]) begin
      lat = tbl[i].lat;
      do_start(tbl[i].mode, tbl[i].key, tbl[i].iv);
      chk({tbl[i].nm, "_key"}, core_key_out, tbl[i].key);
      send(tbl[i].blk, 1'b1);
      recv(1'b0, d, l);
      chk({tbl[i].nm, "_data"}, d, tbl[i].exp);
      chk({tbl[i].nm, "_last"}, 128'(l), 128'd1);
      chk({tbl[i].nm, "_idle"}, 128'({busy_out, s_ready_out}), 128'd0);
    end

    // random 4-block chains, encrypt then decrypt, throttled output, stray starts
    for (int it = 0; it < 3; it++) begin
      k = rnd128(); iv = rnd128();
      prev = iv;
      for (int i = 0; i < 4; i++) begin
        pt[i] = rnd128();
        ct[i] = aes_enc(k, pt[i] ^ prev);
        prev  = ct[i];
      end
      for (int dir = 1; dir >= 0; dir--) begin
        do_start(1'(dir), k, iv);
        for (int i = 0; i < 4; i++) begin
          lat = $urandom_range(2, 7);
          if (i == 1) begin
            do_start(1'(~dir), rnd128(), rnd128());
            chk("accept_start_ignored", {core_key_out[126:0], core_mode_out}, {k[126:0], 1'(dir)});
          end
          send(dir ? pt[i] : ct[i], 1'(i == 3));
          if (i == 2) begin
            @(negedge clk);
            do_start(1'(~dir), rnd128(), rnd128());
            chk("wait_start_ignored", {core_key_out[126:0], core_mode_out}, {k[126:0], 1'(dir)});
          end
          recv(1'b1, d, l);
          chk(dir ? "chain_enc" : "chain_dec", d, dir ? ct[i] : pt[i]);
          chk("chain_last", 128'(l), 128'(i == 3));
          if (i < 3) chk("next_ready_1cyc", 128'(s_ready_out), 128'd1);
          else       chk("chain_done_idle", 128'(busy_out), 128'd0);
        end
      end
    end

    // timeout: dead core, MAX_WAIT = 8
    core_dead = 1'b1;
    k = rnd128(); iv = rnd128(); p = rnd128();
    do_start(1'b1, k, iv);
    send(p, 1'b1);
    chk("issue_init", 128'(core_init_out), 128'd1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("wait_no_error", 128'({error_out, busy_out, core_init_out, s_ready_out}), 128'b0100);
    end
    @(negedge clk);
    chk("timeout_error", 128'({error_out, busy_out, core_init_out, s_ready_out, m_valid_out}), 128'b10000);
    @(negedge clk);
    chk("error_held", 128'(error_out), 128'd1);
    core_dead = 1'b0;
    lat = 4;
    do_start(1'b1, k, iv);
    chk("start_clears_error", 128'({error_out, busy_out}), 128'b01);
    send(p, 1'b1);
    recv(1'b0, d, l);
    chk("after_error_block", d, aes_enc(k, p ^ iv));

    // reset mid-WAIT, late core valid must be ignored
    lat = 6;
    k = rnd128(); iv = rnd128(); p = rnd128();
    do_start(1'b1, k, iv);
    send(p, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_mid_wait", 128'(all_outs()), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      seen |= m_valid_out;
    end
    chk("no_output_after_reset", 128'(seen), 128'd0);
    lat = $urandom_range(2, 7);
    do_start(1'b0, k, iv);
    send(p, 1'b1);
    recv(1'b1, d, l);
    chk("post_reset_dec", d, aes_dec(k, p) ^ iv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_cbc_ctrl.md
AES_CBC_CTRL -- requirements
Module: aes_cbc_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255: cycles allowed in WAIT before timeout.
REQ-002 clk_in  input  1  sole clock, all state on rising edge.
REQ-003 rst_in  input  1  asynchronous, active-high reset.
REQ-004 start_in  input  1  one-cycle pulse; latches key_in, iv_in, mode_in and opens a chain.
REQ-005 mode_in  input  1  1 = CBC encrypt, 0 = CBC decrypt.
REQ-006 key_in / iv_in  input  128 each  AES-128 key / initial chaining value.
REQ-007 s_valid_in, s_ready_out, s_data_in[127:0], s_last_in  in/out/in/in  input block stream; s_last_in marks final block of chain.
REQ-008 m_valid_out, m_ready_in, m_data_out[127:0], m_last_out  out/in/out/out  result stream.
REQ-009 core_init_out, core_mode_out, core_key_out[127:0], core_data_out[127:0]  outputs  drive aes_core init_in/mode_in/key_in/data_in.
REQ-010 core_data_in[127:0], core_valid_in  inputs  from aes_core data_out/valid_out.
REQ-011 busy_out  output  1  high when state is neither IDLE nor ERROR.
REQ-012 error_out  output  1  high in ERROR.
REQ-013 All 128-bit ports share aes_core byte layout (state matrix, row-major); XOR is bytewise, no reordering.

Function
REQ-014 FSM states IDLE, ACCEPT, ISSUE, WAIT, OUTPUT, ERROR.
REQ-015 IDLE: s_ready_out=0; start_in -> latch key, mode, chain=iv_in; -> ACCEPT.
REQ-016 ACCEPT: s_ready_out=1; on s_valid_in&s_ready_out latch block and s_last_in; encrypt: core_data_out = block ^ chain; decrypt: core_data_out = block, block saved as next chain; -> ISSUE.
REQ-017 s_ready_out SHALL be 0 in every state except ACCEPT; at most one block in flight.
REQ-018 ISSUE: core_init_out=1 for exactly one cycle, core_data/key/mode stable from ISSUE through WAIT; -> WAIT, wait counter cleared.
REQ-019 WAIT: core_valid_in ignored in first WAIT cycle (stale valid from previous op); thereafter first cycle with core_valid_in=1 captures result -> OUTPUT.
REQ-020 Encrypt result = core_data_in, chain <= core_data_in; decrypt result = core_data_in ^ chain, chain <= saved ciphertext block.
REQ-021 Wait counter increments each WAIT cycle; reaching MAX_WAIT without valid -> ERROR; core_valid_in on that same cycle wins (capture, no error).
REQ-022 OUTPUT: m_valid_out=1, m_data_out and m_last_out held stable until m_ready_in; on handshake -> IDLE if last, else ACCEPT.
REQ-023 Back-to-back: OUTPUT handshake to next s_ready_out = 1 cycle; block throughput = 1 (accept) + 1 (issue) + core latency + 1 (output minimum).
REQ-024 start_in ignored in ACCEPT, ISSUE, WAIT, OUTPUT; in ERROR it clears error_out and behaves as in IDLE.
REQ-025 ERROR: error_out=1, s_ready_out=0, m_valid_out=0, core_init_out=0; exits only via start_in or reset.
REQ-026 core_key_out and core_mode_out equal latched key/mode at all times after start.

Reset
REQ-027 rst_in asserted at any time (incl. mid-WAIT) -> IDLE immediately; all outputs 0: s_ready_out, m_valid_out, m_data_out, m_last_out, core_init_out, core_mode_out, core_key_out, core_data_out, busy_out, error_out; chain, counter, latched block cleared.
REQ-028 After rst_in deasserts, core results arriving for the aborted block SHALL be ignored (IDLE does not sample core_valid_in).

Verification (bench instantiates real aes_core)
REQ-029 Encrypt, key 2b28ab097eaef7cf15d2154f16a6883c, iv 0, one block 6b2ee973c1403d93be9f7e17e296112a last=1 -> m_data_out 3a0da824d77a9e667b36caefb460f397, m_last_out=1, return to IDLE.
REQ-030 Encrypt, same key, iv 0004080c0105090d02060a0e03070b0f, block 6b2ee973c1403d93be9f7e17e296112a -> 7681ce124919e9e9abb28e19ac469b7d; decrypt of that ciphertext with same key/iv -> original block.
REQ-031 4-block encrypt chain then decrypt chain with same key/iv, m_ready_in randomly throttled -> decrypted stream equals plaintext; m_data_out never changes while m_valid_out=1 & m_ready_in=0.
REQ-032 Stub core that never raises valid, MAX_WAIT=8 -> error_out=1 exactly 8 WAIT cycles after ISSUE; start_in clears it and next block completes.
REQ-033 rst_in pulsed mid-WAIT -> all outputs 0 same cycle; late core valid produces no m_valid_out; new start works.
REQ-034 start_in pulsed during ACCEPT/WAIT -> ignored; chain and key unchanged, results match REQ-031 model.
